// File: rtl/gpac_adc_rx_arbiter_pkg.sv
// Shared types and sizing helpers for the GPAC ADC receiver read arbiter.
package gpac_adc_rx_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = 2;

  // Channel index width; never below one bit so a 2-channel build still has a pointer.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpac_adc_rx_arbiter_rr_sel.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Two passes instead of a modulo rotate: upper segment [ptr..N-1] wins over [0..ptr-1].
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j] && (IW'(j) >= ptr)) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gpac_adc_rx_arbiter.sv
// Round-robin burst arbiter merging per-channel ADC receiver FIFOs into one
// FWFT stream with a 2-entry output buffer.
module gpac_adc_rx_arbiter
  import gpac_adc_rx_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DSIZE    = 32
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RST_N,
  input  logic [CHANNELS-1:0]       CONF_ENABLE,
  input  logic [7:0]                CONF_BURST,
  input  logic [CHANNELS-1:0]       IN_FIFO_EMPTY,
  input  logic [CHANNELS*DSIZE-1:0] IN_FIFO_DATA,
  output logic [CHANNELS-1:0]       IN_FIFO_READ,
  input  logic                      OUT_FIFO_READ,
  output logic                      OUT_FIFO_EMPTY,
  output logic [DSIZE-1:0]          OUT_FIFO_DATA,
  output logic [CHANNELS-1:0]       GRANT,
  output logic                      BUSY
);

  localparam int CH_W = ch_width(CHANNELS);

  arb_state_e           state;
  logic [CH_W-1:0]      ptr, grant, ptr_next;
  logic [7:0]           burst_cnt;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [DSIZE-1:0]     buf0, buf1;

  logic [CHANNELS-1:0]  req, sel_onehot;
  logic                 sel_vld;
  logic [CH_W-1:0]      sel_idx;
  logic                 g_empty, g_en;
  logic [DSIZE-1:0]     g_data;
  logic                 pop, pop_out, burst_hit, release_g;

  assign req = ~IN_FIFO_EMPTY & CONF_ENABLE;

  rr_priority_select #(.N(CHANNELS), .IW(CH_W)) u_rr_sel (
    .req   (req),
    .ptr   (ptr),
    .valid (sel_vld),
    .idx   (sel_idx)
  );

  // Per-channel view of the granted channel.
  always_comb begin
    g_empty    = 1'b1;
    g_en       = 1'b0;
    g_data     = '0;
    sel_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == grant) begin
        g_empty = IN_FIFO_EMPTY[i];
        g_en    = CONF_ENABLE[i];
        g_data  = IN_FIFO_DATA[i*DSIZE +: DSIZE];
      end
      sel_onehot[i] = (CH_W'(i) == sel_idx);
    end
  end

  assign pop       = (state == ARB_XFER) && !g_empty && g_en &&
                     (buf_cnt != BUF_CNT_W'(BUF_DEPTH));
  assign burst_hit = pop && (CONF_BURST != 8'd0) && (burst_cnt == CONF_BURST - 8'd1);
  assign release_g = burst_hit || g_empty || !g_en;
  assign ptr_next  = (grant == CH_W'(CHANNELS-1)) ? '0 : grant + CH_W'(1);
  assign pop_out   = OUT_FIFO_READ && (buf_cnt != '0);

  always_comb begin
    IN_FIFO_READ = '0;
    for (int i = 0; i < CHANNELS; i++)
      IN_FIFO_READ[i] = pop && (CH_W'(i) == grant);
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      GRANT     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_vld) begin
            grant     <= sel_idx;
            burst_cnt <= '0;
            GRANT     <= sel_onehot;
            state     <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          // Saturate so unlimited bursts never wrap into a spurious release.
          if (pop && burst_cnt != 8'hFF)
            burst_cnt <= burst_cnt + 8'd1;
          if (release_g) begin
            state <= ARB_IDLE;
            ptr   <= ptr_next;
            GRANT <= '0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output buffer: buf0 is the head, buf1 the second entry.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      buf_cnt <= '0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({pop, pop_out})
        2'b10: begin
          if (buf_cnt == '0) buf0 <= g_data;
          else               buf1 <= g_data;
          buf_cnt <= buf_cnt + BUF_CNT_W'(1);
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - BUF_CNT_W'(1);
        end
        2'b11: begin
          if (buf_cnt == BUF_CNT_W'(1)) begin
            buf0 <= g_data;
          end else begin
            buf0 <= buf1;
            buf1 <= g_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign OUT_FIFO_EMPTY = (buf_cnt == '0);
  assign OUT_FIFO_DATA  = buf0;
  assign BUSY           = (|req) || (buf_cnt != '0);

endmodule

// File: tb/tb_gpac_adc_rx_arbiter.sv
// Self-checking bench: queue-modelled upstream FIFOs, burst-level round-robin reference.
module tb_gpac_adc_rx_arbiter;

  localparam int CH = 4;
  localparam int DW = 32;

  logic            BUS_CLK, BUS_RST_N;
  logic [CH-1:0]   CONF_ENABLE;
  logic [7:0]      CONF_BURST;
  logic [CH-1:0]   IN_FIFO_EMPTY;
  logic [CH*DW-1:0] IN_FIFO_DATA;
  logic [CH-1:0]   IN_FIFO_READ;
  logic            OUT_FIFO_READ;
  logic            OUT_FIFO_EMPTY;
  logic [DW-1:0]   OUT_FIFO_DATA;
  logic [CH-1:0]   GRANT;
  logic            BUSY;

  gpac_adc_rx_arbiter #(.CHANNELS(CH), .DSIZE(DW)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .CONF_ENABLE(CONF_ENABLE),
    .CONF_BURST(CONF_BURST), .IN_FIFO_EMPTY(IN_FIFO_EMPTY), .IN_FIFO_DATA(IN_FIFO_DATA),
    .IN_FIFO_READ(IN_FIFO_READ), .OUT_FIFO_READ(OUT_FIFO_READ), .OUT_FIFO_EMPTY(OUT_FIFO_EMPTY),
    .OUT_FIFO_DATA(OUT_FIFO_DATA), .GRANT(GRANT), .BUSY(BUSY)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  logic [31:0] q[CH][$];
  logic [31:0] mq[CH][$];
  logic [31:0] exp_q[$];
  logic [31:0] obs[$];
  int          obs_t[$];
  logic [3:0]  glog[$];
  logic [3:0]  gseq[$];
  int          rd_cnt[CH];
  logic [3:0]  rd_s;
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] word(input int tag, input int ch, input int k);
    return {8'(tag), 8'(ch), 16'(k)};
  endfunction

  function automatic void drive();
    for (int i = 0; i < CH; i++) begin
      IN_FIFO_EMPTY[i] = (q[i].size() == 0);
      IN_FIFO_DATA[i*DW +: DW] = (q[i].size() == 0) ? 32'h0 : q[i][0];
    end
  endfunction

  // Upstream FIFO model: sample the pop strobe mid-cycle, pop just after the edge.
  always @(negedge BUS_CLK) begin
    cyc++;
    rd_s = IN_FIFO_READ;
    glog.push_back(GRANT);
    if (OUT_FIFO_READ && !OUT_FIFO_EMPTY) begin
      obs.push_back(OUT_FIFO_DATA);
      obs_t.push_back(cyc);
    end
    if (rd_s != 4'b0) begin
      checks++;
      if ($countones(rd_s) > 1) begin
        errors++;
        $display("FAIL read_onehot: IN_FIFO_READ=%b", rd_s);
      end
    end
  end

  always @(posedge BUS_CLK) begin
    #1;
    for (int i = 0; i < CH; i++) begin
      if (rd_s[i]) begin
        rd_cnt[i]++;
        checks++;
        if (q[i].size() == 0) begin
          errors++;
          $display("FAIL underflow: ch%0d popped while empty", i);
        end else begin
          void'(q[i].pop_front());
        end
      end
    end
    rd_s = 4'b0;
    drive();
  end

  task automatic tick();
    @(posedge BUS_CLK);
    #2;
  endtask

  task automatic push(input int ch, input int n, input int tag);
    for (int k = 0; k < n; k++) q[ch].push_back(word(tag, ch, k));
    drive();
  endtask

  task automatic clear_q();
    for (int i = 0; i < CH; i++) q[i].delete();
    drive();
  endtask

  task automatic clear_logs();
    obs.delete(); obs_t.delete(); glog.delete();
    for (int i = 0; i < CH; i++) rd_cnt[i] = 0;
  endtask

  task automatic do_reset();
    BUS_RST_N = 1'b0;
    tick();
    tick();
    clear_logs();
    BUS_RST_N = 1'b1;
  endtask

  // Reference: whole bursts chosen round-robin from a pointer starting at ch0.
  function automatic void model(input logic [3:0] en, input int burst);
    int p, f, n;
    p = 0;
    exp_q.delete();
    for (int i = 0; i < CH; i++) mq[i] = q[i];
    do begin
      f = -1;
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (p + k) % CH;
        if (f < 0 && en[c[1:0]] && mq[c].size() > 0) f = c;
      end
      if (f >= 0) begin
        n = (burst == 0 || burst > mq[f].size()) ? mq[f].size() : burst;
        for (int k = 0; k < n; k++) exp_q.push_back(mq[f].pop_front());
        p = (f + 1) % CH;
      end
    end while (f >= 0);
  endfunction

  function automatic void build_gseq();
    logic [3:0] prev;
    prev = 4'b0;
    gseq.delete();
    foreach (glog[i]) begin
      if (glog[i] != 4'b0 && glog[i] != prev) gseq.push_back(glog[i]);
      prev = glog[i];
    end
  endfunction

  task automatic run_until(input int n, input bit rnd, input int budget, input string nm);
    int t;
    t = 0;
    while (obs.size() < n && t < budget) begin
      OUT_FIFO_READ = rnd ? 1'($urandom % 2) : 1'b1;
      tick();
      t++;
    end
    OUT_FIFO_READ = 1'b1;
    checks++;
    if (obs.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, need %0d", nm, obs.size(), n);
    end
  endtask

  task automatic test_reset();
    BUS_RST_N = 1'b0;
    #1;
    checks += 5;
    if (GRANT !== 4'b0)           begin errors++; $display("FAIL rst_grant: got %b want 0000", GRANT); end
    if (IN_FIFO_READ !== 4'b0)    begin errors++; $display("FAIL rst_read: got %b want 0000", IN_FIFO_READ); end
    if (OUT_FIFO_EMPTY !== 1'b1)  begin errors++; $display("FAIL rst_empty: got %b want 1", OUT_FIFO_EMPTY); end
    if (OUT_FIFO_DATA !== 32'h0)  begin errors++; $display("FAIL rst_data: got %h want 0", OUT_FIFO_DATA); end
    if (BUSY !== 1'b0)            begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    tick();
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [3:0] rd_exp;
    do_reset();
    CONF_ENABLE = 4'b1111; CONF_BURST = 8'd0; OUT_FIFO_READ = 1'b1;
    push(0, 5, 8'hA0);
    for (int j = 0; j < 10; j++) begin
      @(negedge BUS_CLK);
      rd_exp = (j >= 1 && j <= 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (IN_FIFO_READ !== rd_exp) begin errors++; $display("FAIL single_rd c%0d: got %b want %b", j, IN_FIFO_READ, rd_exp); end
      if (j >= 1 && j <= 5) begin
        checks++;
        if (GRANT !== 4'b0001) begin errors++; $display("FAIL single_grant c%0d: got %b want 0001", j, GRANT); end
      end
      if (j == 0 || j >= 7) begin
        checks++;
        if (GRANT !== 4'b0000) begin errors++; $display("FAIL single_idle c%0d: got %b want 0000", j, GRANT); end
      end
      if (j >= 2 && j <= 6) begin
        checks++;
        if (OUT_FIFO_EMPTY !== 1'b0 || OUT_FIFO_DATA !== word(8'hA0, 0, j-2)) begin
          errors++; $display("FAIL single_data c%0d: got e=%b d=%h want %h", j, OUT_FIFO_EMPTY, OUT_FIFO_DATA, word(8'hA0, 0, j-2));
        end
      end else begin
        checks++;
        if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL single_empty c%0d: got %b want 1", j, OUT_FIFO_EMPTY); end
      end
    end
    tick();
  endtask

  task automatic test_burst_interleave();
    do_reset();
    CONF_ENABLE = 4'b1111; CONF_BURST = 8'd2;
    push(0, 4, 8'h11); push(1, 4, 8'h22);
    model(4'b1111, 2);
    run_until(8, 1'b0, 60, "interleave");
    checks++;
    if (obs.size() != exp_q.size()) begin errors++; $display("FAIL interleave_len: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL interleave_w%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
    if (obs_t.size() >= 3) begin
      checks += 2;
      if (obs_t[1] - obs_t[0] != 1) begin errors++; $display("FAIL interleave_stream: gap got %0d want 1", obs_t[1]-obs_t[0]); end
      if (obs_t[2] - obs_t[1] != 2) begin errors++; $display("FAIL interleave_gap: gap got %0d want 2", obs_t[2]-obs_t[1]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    CONF_ENABLE = 4'b1111; CONF_BURST = 8'd0; OUT_FIFO_READ = 1'b0;
    push(2, 3, 8'hC0);
    model(4'b1111, 0);
    repeat (8) tick();
    checks += 5;
    if (rd_cnt[2] != 2)           begin errors++; $display("FAIL stall_pops: got %0d want 2", rd_cnt[2]); end
    if (GRANT !== 4'b0100)        begin errors++; $display("FAIL stall_grant: got %b want 0100", GRANT); end
    if (IN_FIFO_READ !== 4'b0)    begin errors++; $display("FAIL stall_rd: got %b want 0000", IN_FIFO_READ); end
    if (OUT_FIFO_EMPTY !== 1'b0)  begin errors++; $display("FAIL stall_empty: got %b want 0", OUT_FIFO_EMPTY); end
    if (OUT_FIFO_DATA !== exp_q[0]) begin errors++; $display("FAIL stall_head: got %h want %h", OUT_FIFO_DATA, exp_q[0]); end
    run_until(3, 1'b0, 30, "stall_drain");
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL stall_w%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_mask();
    logic [3:0] g;
    bit seen;
    do_reset();
    CONF_ENABLE = 4'b1010; CONF_BURST = 8'd2;
    for (int i = 0; i < CH; i++) push(i, 6, 8'h30 + i);
    model(4'b1010, 2);
    run_until(exp_q.size(), 1'b1, 400, "mask");
    repeat (4) tick();
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL mask_w%0d: got %h want %h", i, obs[i], exp_q[i]); end
    end
    build_gseq();
    checks++;
    if (gseq.size() != 6) begin errors++; $display("FAIL mask_nbursts: got %0d want 6", gseq.size()); end
    for (int i = 0; i < gseq.size(); i++) begin
      g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (gseq[i] !== g) begin errors++; $display("FAIL mask_grant%0d: got %b want %b", i, gseq[i], g); end
    end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL mask_busy: got %b want 0", BUSY); end

    clear_q();
    do_reset();
    CONF_ENABLE = 4'b1010; CONF_BURST = 8'd0;
    push(1, 10, 8'h41); push(3, 2, 8'h43);
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = (GRANT == 4'b0010); end
    checks++;
    if (!seen) begin errors++; $display("FAIL mask_wait: ch1 never granted, GRANT=%b", GRANT); end
    tick();
    CONF_ENABLE = 4'b1000;
    @(negedge BUS_CLK);
    checks++;
    if (IN_FIFO_READ !== 4'b0) begin errors++; $display("FAIL mask_rdoff: got %b want 0000", IN_FIFO_READ); end
    @(negedge BUS_CLK);
    checks++;
    if (GRANT !== 4'b0) begin errors++; $display("FAIL mask_release: got %b want 0000", GRANT); end
    @(negedge BUS_CLK);
    checks++;
    if (GRANT !== 4'b1000) begin errors++; $display("FAIL mask_next: got %b want 1000", GRANT); end
    tick();
    repeat (4) tick();
    clear_q();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] g;
    bit seen;
    do_reset();
    CONF_ENABLE = 4'b1111; CONF_BURST = 8'd1; OUT_FIFO_READ = 1'b1;
    push(3, 2, 8'h53);
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = (GRANT == 4'b1000); end
    checks++;
    if (!seen) begin errors++; $display("FAIL wrap_wait: ch3 never granted, GRANT=%b", GRANT); end
    push(0, 2, 8'h50);
    run_until(4, 1'b0, 40, "wrap");
    repeat (4) tick();
    build_gseq();
    checks++;
    if (gseq.size() != 4) begin errors++; $display("FAIL wrap_n: got %0d grants want 4", gseq.size()); end
    for (int i = 0; i < gseq.size(); i++) begin
      g = (i % 2 == 0) ? 4'b1000 : 4'b0001;
      checks++;
      if (gseq[i] !== g) begin errors++; $display("FAIL wrap_grant%0d: got %b want %b", i, gseq[i], g); end
    end
  endtask

  task automatic test_reset_mid();
    int snap;
    bit seen;
    do_reset();
    CONF_ENABLE = 4'b1111; CONF_BURST = 8'd0; OUT_FIFO_READ = 1'b1;
    push(1, 1, 8'h61);
    run_until(1, 1'b0, 20, "rstmid_pre");
    repeat (3) tick();
    OUT_FIFO_READ = 1'b0;
    push(2, 4, 8'h62);
    repeat (5) tick();
    push(0, 2, 8'h60);
    checks++;
    if (OUT_FIFO_EMPTY !== 1'b0 || GRANT !== 4'b0100) begin
      errors++; $display("FAIL rstmid_setup: got e=%b g=%b want 0/0100", OUT_FIFO_EMPTY, GRANT);
    end
    BUS_RST_N = 1'b0;
    #1;
    checks += 4;
    if (OUT_FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", OUT_FIFO_EMPTY); end
    if (GRANT !== 4'b0)          begin errors++; $display("FAIL rstmid_grant: got %b want 0000", GRANT); end
    if (IN_FIFO_READ !== 4'b0)   begin errors++; $display("FAIL rstmid_rd: got %b want 0000", IN_FIFO_READ); end
    if (OUT_FIFO_DATA !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", OUT_FIFO_DATA); end
    snap = rd_cnt[2];
    tick(); tick();
    checks++;
    if (rd_cnt[2] != snap) begin errors++; $display("FAIL rstmid_nopop: got %0d pops want %0d", rd_cnt[2], snap); end
    BUS_RST_N = 1'b1;
    OUT_FIFO_READ = 1'b1;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin tick(); seen = (GRANT != 4'b0); end
    checks++;
    if (GRANT !== 4'b0001) begin errors++; $display("FAIL rstmid_restart: got %b want 0001", GRANT); end
    repeat (12) tick();
    clear_q();
  endtask

  task automatic test_random();
    logic [3:0] en;
    int bl;
    for (int it = 0; it < 8; it++) begin
      clear_q();
      do_reset();
      en = 4'($urandom_range(1, 15));
      bl = $urandom_range(0, 3);
      CONF_ENABLE = en; CONF_BURST = 8'(bl);
      for (int i = 0; i < CH; i++) push(i, $urandom_range(0, 5), 8'h80 + it);
      model(en, bl);
      run_until(exp_q.size(), 1'b1, 400, "random");
      repeat (4) tick();
      checks++;
      if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", it, obs.size(), exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_w%0d: got %h want %h", it, i, obs[i], exp_q[i]); end
      end
      checks += 2;
      if (BUSY !== 1'b0)  begin errors++; $display("FAIL rand%0d_busy: got %b want 0", it, BUSY); end
      if (GRANT !== 4'b0) begin errors++; $display("FAIL rand%0d_grant: got %b want 0000", it, GRANT); end
    end
    clear_q();
  endtask

  initial begin
    BUS_RST_N = 1'b0; CONF_ENABLE = 4'b0; CONF_BURST = 8'd0; OUT_FIFO_READ = 1'b0;
    rd_s = 4'b0; cyc = 0;
    drive();
    tick();
    test_reset();
    test_single_burst();
    test_burst_interleave();
    test_stall();
    test_enable_mask();
    test_ptr_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
